// File: rtl/rc4_search_pkg.sv
// Shared types and constants for the RC4 multi-core key search controller.
package rc4_search_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_FOUND,
    ST_EXHAUSTED
  } search_state_t;

  localparam int DEFAULT_KEY_WIDTH = 24;
  localparam int MAX_CORES         = 16;

  // Index width for an N-way selector; a single core still needs one bit.
  function automatic int arb_idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rc4_key_search_ctrl_if.sv
// Controller-to-decryption-core bus: start/key/stop out, done/valid back.
interface rc4_key_search_ctrl_if #(
  parameter int NUM_CORES = 4,
  parameter int KEY_WIDTH = 24
);

  logic [NUM_CORES-1:0]           core_start;
  logic [NUM_CORES*KEY_WIDTH-1:0] core_key;
  logic                           core_stop;
  logic [NUM_CORES-1:0]           core_done;
  logic [NUM_CORES-1:0]           core_valid;

  modport master (
    output core_start,
    output core_key,
    output core_stop,
    input  core_done,
    input  core_valid
  );

  modport slave (
    input  core_start,
    input  core_key,
    input  core_stop,
    output core_done,
    output core_valid
  );

endinterface

// File: rtl/rc4_core_arbiter.sv
// Fixed-priority lowest-set-bit finder: one-hot grant plus binary index.
module rc4_core_arbiter
  import rc4_search_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]                  req,
  output logic [N-1:0]                  grant,
  output logic [arb_idx_width(N)-1:0]   index
);

  localparam int IW = arb_idx_width(N);

  // Two's-complement trick isolates the lowest set bit.
  assign grant = req & (~req + N'(1));

  always_comb begin
    index = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) index = IW'(i);
    end
  end

endmodule

// File: rtl/rc4_key_search_ctrl.sv
// Hands keys from [key_lo, key_hi] to parallel decryption cores and stops on
// the first readable plaintext or when every key in the range has completed.
module rc4_key_search_ctrl
  import rc4_search_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int KEY_WIDTH = DEFAULT_KEY_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [KEY_WIDTH-1:0] key_lo,
  input  logic [KEY_WIDTH-1:0] key_hi,
  rc4_key_search_ctrl_if.master core_bus,
  output logic                 busy,
  output logic                 found,
  output logic                 exhausted,
  output logic [KEY_WIDTH-1:0] found_key,
  output logic [KEY_WIDTH:0]   keys_tried
);

  localparam int IW   = arb_idx_width(NUM_CORES);
  localparam int CNTW = $clog2(MAX_CORES + 1);

  search_state_t        state_reg;
  logic [KEY_WIDTH-1:0] key_hi_reg;
  logic [KEY_WIDTH-1:0] next_key_reg;
  logic                 range_done_reg;
  logic [NUM_CORES-1:0] busy_flag_reg;
  logic [NUM_CORES-1:0] core_start_reg;
  logic                 core_stop_reg;
  logic [KEY_WIDTH-1:0] core_key_reg [NUM_CORES];
  logic                 found_reg;
  logic                 exhausted_reg;
  logic [KEY_WIDTH-1:0] found_key_reg;
  logic [KEY_WIDTH:0]   keys_tried_reg;

  logic                 active;
  logic [NUM_CORES-1:0] done_eff;
  logic [NUM_CORES-1:0] hit_req;
  logic [NUM_CORES-1:0] idle_req;
  logic [NUM_CORES-1:0] idle_grant;
  logic [NUM_CORES-1:0] hit_grant;
  logic [IW-1:0]        idle_idx;
  logic [IW-1:0]        hit_idx;
  logic                 hit;
  logic [CNTW-1:0]      done_cnt;

  assign active   = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
  // A done on an idle core is a protocol error and is masked out here.
  assign done_eff = core_bus.core_done & busy_flag_reg & {NUM_CORES{active}};
  assign hit_req  = done_eff & core_bus.core_valid;
  assign idle_req = ~busy_flag_reg & ~core_bus.core_done;
  assign hit      = |hit_grant;

  rc4_core_arbiter #(.N(NUM_CORES)) u_idle_arb (
    .req   (idle_req),
    .grant (idle_grant),
    .index (idle_idx)
  );

  rc4_core_arbiter #(.N(NUM_CORES)) u_hit_arb (
    .req   (hit_req),
    .grant (hit_grant),
    .index (hit_idx)
  );

  always_comb begin
    done_cnt = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      done_cnt = done_cnt + CNTW'(done_eff[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      key_hi_reg     <= '0;
      next_key_reg   <= '0;
      range_done_reg <= 1'b0;
      busy_flag_reg  <= '0;
      core_start_reg <= '0;
      core_stop_reg  <= 1'b0;
      found_reg      <= 1'b0;
      exhausted_reg  <= 1'b0;
      found_key_reg  <= '0;
      keys_tried_reg <= '0;
      for (int i = 0; i < NUM_CORES; i++) core_key_reg[i] <= '0;
    end else begin
      core_start_reg <= '0;
      core_stop_reg  <= 1'b0;
      case (state_reg)
        ST_IDLE, ST_FOUND, ST_EXHAUSTED: begin
          if (start) begin
            key_hi_reg     <= key_hi;
            keys_tried_reg <= '0;
            found_reg      <= 1'b0;
            exhausted_reg  <= 1'b0;
            next_key_reg   <= key_lo;
            if (key_lo > key_hi) begin
              range_done_reg <= 1'b1;
              state_reg      <= ST_EXHAUSTED;
            end else begin
              // All cores are idle here, so the first key goes straight to core 0.
              core_start_reg  <= NUM_CORES'(1);
              busy_flag_reg   <= NUM_CORES'(1);
              core_key_reg[0] <= key_lo;
              range_done_reg  <= (key_lo == key_hi);
              if (key_lo != key_hi) next_key_reg <= key_lo + KEY_WIDTH'(1);
              state_reg       <= ST_RUN;
            end
          end else if (state_reg == ST_EXHAUSTED) begin
            exhausted_reg <= 1'b1;
          end
        end
        ST_RUN, ST_DRAIN: begin
          keys_tried_reg <= keys_tried_reg + (KEY_WIDTH + 1)'(done_cnt);
          if (hit) begin
            found_key_reg <= core_key_reg[hit_idx];
            found_reg     <= 1'b1;
            core_stop_reg <= 1'b1;
            busy_flag_reg <= '0;
            state_reg     <= ST_FOUND;
          end else if ((state_reg == ST_RUN) && !range_done_reg && (|idle_grant)) begin
            core_start_reg         <= idle_grant;
            core_key_reg[idle_idx] <= next_key_reg;
            busy_flag_reg          <= (busy_flag_reg & ~done_eff) | idle_grant;
            // Stop on key_hi instead of incrementing so the top key never wraps.
            if (next_key_reg == key_hi_reg) range_done_reg <= 1'b1;
            else                            next_key_reg   <= next_key_reg + KEY_WIDTH'(1);
          end else begin
            busy_flag_reg <= busy_flag_reg & ~done_eff;
            if ((state_reg == ST_RUN) && range_done_reg) begin
              state_reg <= ST_DRAIN;
            end else if ((state_reg == ST_DRAIN) && (busy_flag_reg == '0)) begin
              exhausted_reg <= 1'b1;
              state_reg     <= ST_EXHAUSTED;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  logic [NUM_CORES*KEY_WIDTH-1:0] core_key_flat;

  genvar gi;
  for (gi = 0; gi < NUM_CORES; gi++) begin : g_key_pack
    assign core_key_flat[gi*KEY_WIDTH +: KEY_WIDTH] = core_key_reg[gi];
  end

  assign core_bus.core_key   = core_key_flat;
  assign core_bus.core_start = core_start_reg;
  assign core_bus.core_stop  = core_stop_reg;
  assign busy                = active;
  assign found               = found_reg;
  assign exhausted           = exhausted_reg;
  assign found_key           = found_key_reg;
  assign keys_tried          = keys_tried_reg;

endmodule

// File: tb/tb_rc4_key_search_ctrl.sv
// Directed bench for rc4_key_search_ctrl with behavioural cores and a key/result scoreboard.
module tb_rc4_key_search_ctrl;

  localparam int NC = 4;
  localparam int KW = 24;

  typedef struct {
    bit          found;
    bit          exh;
    logic [23:0] fkey;
    bit          chk_tried;
    logic [24:0] tried;
  } res_t;

  logic          clk;
  logic          reset;
  logic          start;
  logic [KW-1:0] key_lo;
  logic [KW-1:0] key_hi;
  logic          busy;
  logic          found;
  logic          exhausted;
  logic [KW-1:0] found_key;
  logic [KW:0]   keys_tried;

  rc4_key_search_ctrl_if #(.NUM_CORES(NC), .KEY_WIDTH(KW)) bus ();

  rc4_key_search_ctrl #(.NUM_CORES(NC), .KEY_WIDTH(KW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .key_lo     (key_lo),
    .key_hi     (key_hi),
    .core_bus   (bus),
    .busy       (busy),
    .found      (found),
    .exhausted  (exhausted),
    .found_key  (found_key),
    .keys_tried (keys_tried)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          total;
  int          bad;
  logic [23:0] exp_key_q [$];
  res_t        res_q [$];
  int          lat_tab [NC];
  int          cnt [NC];
  logic [23:0] ckey [NC];
  int          valid_a;
  int          valid_b;
  int          n_starts;
  int          stop_pulses;
  int          post_end_starts;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: monitor dispatches at the falling edge, then step the core models.
  task automatic tick();
    logic [NC-1:0] d;
    logic [NC-1:0] v;
    logic [NC-1:0] fresh;
    logic [23:0]   k;
    @(negedge clk);
    fresh = '0;
    if (bus.core_start != '0) begin
      check("start_onehot", 64'($countones(bus.core_start)), 64'd1);
      for (int i = 0; i < NC; i++) begin
        if (bus.core_start[i]) begin
          n_starts++;
          if (found || exhausted) post_end_starts++;
          k = bus.core_key[i*KW +: KW];
          if (exp_key_q.size() == 0) check("dispatch_pending", 64'(exp_key_q.size()), 64'd1);
          else                       check("dispatch_key", 64'(k), 64'(exp_key_q.pop_front()));
          cnt[i]   = lat_tab[i];
          ckey[i]  = k;
          fresh[i] = 1'b1;
        end
      end
    end
    if (bus.core_stop) begin
      stop_pulses++;
      for (int i = 0; i < NC; i++) cnt[i] = 0;
    end
    if (reset) begin
      for (int i = 0; i < NC; i++) cnt[i] = 0;
    end
    d = '0;
    v = '0;
    for (int i = 0; i < NC; i++) begin
      if (!fresh[i] && cnt[i] > 0) begin
        cnt[i]--;
        if (cnt[i] == 0) begin
          d[i] = 1'b1;
          v[i] = (int'(ckey[i]) == valid_a) || (int'(ckey[i]) == valid_b);
        end
      end
    end
    bus.core_done  = d;
    bus.core_valid = v;
  endtask

  task automatic run_search(input logic [23:0] lo, input logic [23:0] hi, input bit exp_found,
                            input logic [23:0] exp_fkey, input bit chk_tried,
                            input logic [24:0] exp_tried, input bit poke);
    res_t r;
    res_t e;
    int   t;
    for (longint kk = longint'(lo); kk <= longint'(hi); kk++) exp_key_q.push_back(kk[23:0]);
    r.found = exp_found; r.exh = !exp_found; r.fkey = exp_fkey;
    r.chk_tried = chk_tried; r.tried = exp_tried;
    res_q.push_back(r);
    n_starts = 0; stop_pulses = 0; post_end_starts = 0;
    key_lo = lo; key_hi = hi; start = 1'b1;
    tick();
    start = 1'b0;
    check("first_start_latency", 64'(n_starts), 64'd1);
    t = 0;
    while (t < 400 && !(found || exhausted)) begin
      if (poke && t == 2) begin
        key_lo = 24'h90; key_hi = 24'h80; start = 1'b1;
      end
      tick();
      start = 1'b0;
      t++;
    end
    check("search_ended", 64'(found || exhausted), 64'd1);
    e = res_q.pop_front();
    check("found", 64'(found), 64'(e.found));
    check("exhausted", 64'(exhausted), 64'(e.exh));
    check("busy_at_end", 64'(busy), 64'd0);
    if (e.found) check("found_key", 64'(found_key), 64'(e.fkey));
    if (e.chk_tried) check("keys_tried", 64'(keys_tried), 64'(e.tried));
    $display("search lo=%06h hi=%06h found=%0d exhausted=%0d found_key=%06h keys_tried=%0d",
             lo, hi, found, exhausted, found_key, keys_tried);
    for (int i = 0; i < 12; i++) tick();
    check("starts_after_end", 64'(post_end_starts), 64'd0);
    check("stop_pulses", 64'(stop_pulses), 64'(e.found));
    check("n_starts", 64'(n_starts), 64'(longint'(hi) - longint'(lo) + 1));
    check("key_queue_drained", 64'(exp_key_q.size()), 64'd0);
    check("result_held", 64'(found), 64'(e.found));
  endtask

  initial begin
    total = 0; bad = 0;
    reset = 1'b1; start = 1'b0; key_lo = '0; key_hi = '0;
    bus.core_done = '0; bus.core_valid = '0;
    valid_a = -1; valid_b = -1;
    for (int i = 0; i < NC; i++) begin
      lat_tab[i] = 10; cnt[i] = 0; ckey[i] = '0;
    end
    n_starts = 0; stop_pulses = 0; post_end_starts = 0;
    tick();
    tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_found", 64'(found), 64'd0);
    check("rst_exhausted", 64'(exhausted), 64'd0);
    check("rst_found_key", 64'(found_key), 64'd0);
    check("rst_keys_tried", 64'(keys_tried), 64'd0);
    check("rst_core_start", 64'(bus.core_start), 64'd0);
    check("rst_core_stop", 64'(bus.core_stop), 64'd0);
    check("rst_core_key", 64'(bus.core_key), 64'd0);
    reset = 1'b0;
    tick();

    // Eight keys, key 5 decrypts.
    valid_a = 5;
    run_search(24'h0, 24'h7, 1'b1, 24'h5, 1'b0, 25'd0, 1'b0);

    // No hit; a stray start mid-run must not disturb the range.
    valid_a = -1;
    run_search(24'h10, 24'h13, 1'b0, 24'h0, 1'b1, 25'd4, 1'b1);

    // Empty range.
    n_starts = 0;
    key_lo = 24'h20; key_hi = 24'h1F; start = 1'b1;
    tick();
    start = 1'b0;
    check("empty_exh_early", 64'(exhausted), 64'd0);
    check("empty_busy", 64'(busy), 64'd0);
    tick();
    check("empty_exh", 64'(exhausted), 64'd1);
    check("empty_tried", 64'(keys_tried), 64'd0);
    check("empty_found", 64'(found), 64'd0);
    for (int i = 0; i < 4; i++) tick();
    check("empty_starts", 64'(n_starts), 64'd0);
    $display("search lo=000020 hi=00001f exhausted=%0d keys_tried=%0d", exhausted, keys_tried);

    // Top of key space: no wrap to zero.
    run_search(24'hFFFFFE, 24'hFFFFFF, 1'b0, 24'h0, 1'b1, 25'd2, 1'b0);

    // Cores 1 and 3 hit in the same cycle; lower index wins, both completions count.
    lat_tab[0] = 20; lat_tab[1] = 12; lat_tab[2] = 20; lat_tab[3] = 10;
    valid_a = 'h41; valid_b = 'h43;
    run_search(24'h40, 24'h43, 1'b1, 24'h41, 1'b1, 25'd2, 1'b0);

    // Reset five cycles into a long search.
    for (int i = 0; i < NC; i++) lat_tab[i] = 10;
    valid_a = -1; valid_b = -1;
    for (int kk = 0; kk < 4; kk++) exp_key_q.push_back(24'(kk));
    key_lo = 24'd0; key_hi = 24'd100; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("pre_reset_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_found_key", 64'(found_key), 64'd0);
    check("arst_core_key", 64'(bus.core_key), 64'd0);
    check("arst_core_start", 64'(bus.core_start), 64'd0);
    check("arst_core_stop", 64'(bus.core_stop), 64'd0);
    check("arst_keys_tried", 64'(keys_tried), 64'd0);
    check("arst_queue", 64'(exp_key_q.size()), 64'd0);
    $display("reset applied mid-search busy=%0d keys_tried=%0d", busy, keys_tried);
    tick();
    reset = 1'b0;
    tick();
    run_search(24'h0, 24'h3, 1'b0, 24'h0, 1'b1, 25'd4, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
